// File: rtl/fetch_queue.sv
// Instruction fetch stage: PC register, imem addressing and a small {instr, pc} FIFO toward decode.
// Optional FETCH_HALT_EN macro stops fetching after the halt word (CBZ XZR,#0) is enqueued.
module fetch_queue #(
  parameter int N     = 64,
  parameter int IW    = 32,
  parameter int AW    = 6,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  output logic [AW-1:0]    imem_addr,
  input  logic [IW-1:0]    imem_q,
  input  logic             redirect_valid,
  input  logic [N-1:0]     redirect_pc,
  output logic             instr_valid,
  output logic [IW-1:0]    instr,
  output logic [N-1:0]     instr_pc,
  input  logic             instr_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic             halted
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [N-1:0]  pc_reg, pc_next;
  logic [PW-1:0] head_reg, head_next;
  logic [PW-1:0] tail_reg, tail_next;
  logic [CW-1:0] count_reg, count_next;
  logic          pop, push;

  logic [IW-1:0] mem_instr [DEPTH];
  logic [N-1:0]  mem_pc    [DEPTH];

  // Low two bits of a redirect target are discarded (word-aligned fetch).
  logic unused_redirect_bits;
  assign unused_redirect_bits = ^redirect_pc[1:0];

`ifdef FETCH_HALT_EN
  localparam logic [IW-1:0] HALT_WORD = IW'(32'hB400001F);
  logic halted_reg;
  assign halted = halted_reg;
`else
  assign halted = 1'b0;
`endif

  assign imem_addr   = pc_reg[AW+1:2];
  assign instr_valid = (count_reg != '0);
  assign instr       = mem_instr[head_reg];
  assign instr_pc    = mem_pc[head_reg];
  assign count       = count_reg;

  always_comb begin
    pop  = instr_valid & instr_ready;
    push = !redirect_valid && !halted && ((count_reg < CW'(DEPTH)) || pop);

    pc_next    = pc_reg;
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;

    if (redirect_valid) begin
      // A same-cycle pop still counts as accepted; the whole queue is dropped.
      pc_next    = {redirect_pc[N-1:2], 2'b00};
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      if (push) begin
        pc_next   = pc_reg + N'(4);
        tail_next = tail_reg + PW'(1);
      end
      if (pop) begin
        head_next = head_reg + PW'(1);
      end
      count_next = count_reg + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_reg    <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      pc_reg    <= pc_next;
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Storage has no reset: contents are only observable through count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[tail_reg] <= imem_q;
      mem_pc[tail_reg]    <= pc_reg;
    end
  end

`ifdef FETCH_HALT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      halted_reg <= 1'b0;
    end else if (redirect_valid) begin
      halted_reg <= 1'b0;
    end else if (push && (imem_q == HALT_WORD)) begin
      halted_reg <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios then random traffic against a queue-based model.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  imem_addr;
  logic [31:0] imem_q;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_ready;
  logic [2:0]  count;
  logic        halted;

  logic [31:0] rom [64];
  assign imem_q = rom[imem_addr];

  always #5 clk = ~clk;

  fetch_queue dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_q         (imem_q),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .count          (count),
    .halted         (halted)
  );

  typedef struct {
    logic [31:0] w;
    logic [63:0] pc;
  } ent_t;

  ent_t        q[$];
  logic [63:0] mpc;
  bit          mh;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic cycle(input bit rst_n, input bit rv, input logic [63:0] rpc, input bit rdy);
    bit   pop, push;
    ent_t e;
    reset          = rst_n;
    redirect_valid = rv;
    redirect_pc    = rpc;
    instr_ready    = rdy;
    pop  = (q.size() > 0) && rdy;
    push = !rv && !mh && ((q.size() < 4) || pop);
    if (!rst_n) begin
      q.delete();
      mpc = 64'd0;
      mh  = 1'b0;
    end else if (rv) begin
      q.delete();
      mpc = {rpc[63:2], 2'b00};
      mh  = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        e.w  = rom[mpc[7:2]];
        e.pc = mpc;
        q.push_back(e);
`ifdef FETCH_HALT_EN
        if (e.w == 32'hB400001F) mh = 1'b1;
`endif
        mpc = mpc + 64'd4;
      end
    end
    @(posedge clk);
    #1;
    chk("count", 64'(count), 64'(q.size()));
    chk("instr_valid", 64'(instr_valid), 64'(q.size() > 0));
    chk("imem_addr", 64'(imem_addr), 64'(mpc[7:2]));
    chk("halted", 64'(halted), 64'(mh));
    if (q.size() > 0) begin
      chk("instr", 64'(instr), 64'(q[0].w));
      chk("instr_pc", instr_pc, q[0].pc);
    end
    $display("t=%0t rst=%0b rv=%0b rpc=%h rdy=%0b -> valid=%0b instr=%h pc=%h count=%0d halted=%0b",
             $time, rst_n, rv, rpc, rdy, instr_valid, instr, instr_pc, count, halted);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'h8B000000 | 32'(i);
    rom[0]  = 32'hF8000001;
    rom[1]  = 32'hF8008002;
    rom[2]  = 32'hF8000203;
    rom[28] = 32'hB4000040;
    rom[46] = 32'hB400001F;
    for (int i = 47; i < 64; i++) rom[i] = 32'h0;
    mpc = 64'd0;
    mh  = 1'b0;
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;

    // Reset state
    cycle(0, 0, 64'd0, 1);
    cycle(0, 1, 64'h40, 1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(instr_valid), 64'd0);

    // Release with ready=1: one instruction per cycle
    cycle(1, 0, 64'd0, 1);
    chk("first_instr", 64'(instr), 64'hF8000001);
    chk("first_pc", instr_pc, 64'd0);
    cycle(1, 0, 64'd0, 1);
    chk("second_instr", 64'(instr), 64'hF8008002);
    cycle(1, 0, 64'd0, 1);
    chk("third_instr", 64'(instr), 64'hF8000203);
    chk("third_pc", instr_pc, 64'd8);

    // Backpressure: fill and hold, then drain without gaps
    cycle(0, 0, 64'd0, 0);
    for (int i = 0; i < 10; i++) cycle(1, 0, 64'd0, 0);
    chk("full_count", 64'(count), 64'd4);
    chk("full_addr", 64'(imem_addr), 64'd4);
    chk("full_head_pc", instr_pc, 64'd0);
    for (int i = 0; i < 6; i++) cycle(1, 0, 64'd0, 1);

    // Redirect with count=3 and a same-cycle pop
    cycle(0, 0, 64'd0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 64'd0, 0);
    chk("pre_redir_count", 64'(count), 64'd3);
    cycle(1, 1, 64'h70, 1);
    chk("redir_count", 64'(count), 64'd0);
    chk("redir_valid", 64'(instr_valid), 64'd0);
    cycle(1, 0, 64'd0, 0);
    chk("redir_instr", 64'(instr), 64'hB4000040);
    chk("redir_pc", instr_pc, 64'h70);

    // Reset while full
    for (int i = 0; i < 4; i++) cycle(1, 0, 64'd0, 0);
    chk("mid_full", 64'(count), 64'd4);
    cycle(0, 0, 64'd0, 1);
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_addr", 64'(imem_addr), 64'd0);
    cycle(1, 0, 64'd0, 1);
    chk("mid_rst_first", 64'(instr), 64'hF8000001);

    // Unaligned redirect and imem address wrap
    cycle(1, 1, 64'hFD, 0);
    chk("wrap_addr63", 64'(imem_addr), 64'd63);
    cycle(1, 0, 64'd0, 0);
    chk("wrap_pc_fc", instr_pc, 64'hFC);
    chk("wrap_instr0", 64'(instr), 64'h0);
    chk("wrap_addr0", 64'(imem_addr), 64'd0);
    cycle(1, 0, 64'd0, 1);
    chk("wrap_pc_100", instr_pc, 64'h100);
    chk("wrap_instr", 64'(instr), 64'hF8000001);

    // Halt word at 0xB8
    cycle(1, 1, 64'hB8, 0);
    cycle(1, 0, 64'd0, 0);
    chk("halt_word", 64'(instr), 64'hB400001F);
    chk("halt_pc", instr_pc, 64'hB8);
    cycle(1, 0, 64'd0, 1);
`ifdef FETCH_HALT_EN
    chk("halt_flag", 64'(halted), 64'd1);
    chk("halt_drained", 64'(count), 64'd0);
    for (int i = 0; i < 4; i++) cycle(1, 0, 64'd0, 1);
    chk("halt_no_more", 64'(count), 64'd0);
    chk("halt_addr", 64'(imem_addr), 64'(8'hBC >> 2));
`else
    chk("nohalt_pc", instr_pc, 64'hBC);
    chk("nohalt_instr", 64'(instr), 64'h0);
`endif

    // Random traffic
    cycle(0, 0, 64'd0, 0);
    for (int i = 0; i < 600; i++) begin
      bit          rst_n, rv, rdy;
      logic [63:0] rpc;
      rst_n = ($urandom_range(0, 63) != 0);
      rv    = ($urandom_range(0, 11) == 0);
      rdy   = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) rpc = {$urandom, $urandom};
      else rpc = 64'($urandom_range(0, 511));
      cycle(rst_n, rv, rpc, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
